iopmp_cfg_sequencer: RTL

Boot-time programming engine for `iopmp_control_port`. On `start_i` it walks a parameterised command list and issues one TL-UL transaction per command on the control port's host interface (`tl_h2d_t`/`tl_d2h_t`), one outstanding at a time. It sits between the SoC reset/boot logic and the control port's `mst_req_i`/`slv_rsp_o`. It replaces hand-sequenced register writes: HWCFG, ERR_CFG, MDCFG, SRCMD_EN, ENTRY_ADDR, ENTRY_CFG.

---
 rtl/iopmp_pkg.sv | 35 +++
 rtl/tlul_pkg.sv | 39 +++
 rtl/top_pkg.sv | 9 +
 rtl/iopmp_seq_timer.sv | 30 +++
 rtl/iopmp_cfg_sequencer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/iopmp_pkg.sv
// Types shared by the IOPMP configuration sequencer: FSM state, error code,
// command slot record and the masked readback compare.
package iopmp_pkg;
    import top_pkg::*;

    typedef enum logic [2:0] {
        SEQ_IDLE    = 3'd0,
        SEQ_REQ     = 3'd1,
        SEQ_RSP     = 3'd2,
        SEQ_CHK_REQ = 3'd3,
        SEQ_CHK_RSP = 3'd4,
        SEQ_DONE    = 3'd5
    } iopmp_seq_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_DERR     = 2'd1,
        ERR_MISMATCH = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } iopmp_seq_err_e;

    typedef struct packed {
        logic             op;     // 1 = PutFullData, 0 = Get
        logic [TL_AW-1:0] addr;
        logic [TL_DW-1:0] data;
        logic [TL_DW-1:0] vmask;
    } iopmp_seq_cmd_t;

    // A zero mask never reports a mismatch, which is how a slot opts out.
    function automatic logic masked_mismatch(input logic [TL_DW-1:0] rdata,
                                             input logic [TL_DW-1:0] expected,
                                             input logic [TL_DW-1:0] vmask);
        return |((rdata ^ expected) & vmask);
    endfunction
endpackage

// File: rtl/tlul_pkg.sv
// TL-UL opcodes and host/device channel structs.
package tlul_pkg;
    import top_pkg::*;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic                  a_valid;
        tl_a_op_e              a_opcode;
        logic [2:0]            a_param;
        logic [TL_SZW-1:0]     a_size;
        logic [TL_AIW-1:0]     a_source;
        logic [TL_AW-1:0]      a_address;
        logic [TL_DBW-1:0]     a_mask;
        logic [TL_DW-1:0]      a_data;
        logic                  d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                  d_valid;
        tl_d_op_e              d_opcode;
        logic [2:0]            d_param;
        logic [TL_SZW-1:0]     d_size;
        logic [TL_AIW-1:0]     d_source;
        logic [TL_DIW-1:0]     d_sink;
        logic [TL_DW-1:0]      d_data;
        logic                  d_error;
        logic                  a_ready;
    } tl_d2h_t;
endpackage

// File: rtl/top_pkg.sv
// Global bus widths for the TL-UL fabric.
package top_pkg;
    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_SZW = 2;
endpackage

// File: rtl/iopmp_seq_timer.sv
// Wait counter for the sequencer's handshake states.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clr         - restart the count from zero (state entry)
//   en          - count this cycle (in a waiting state)
//   expired     - count has reached TIMEOUT_CYCLES-1 while enabled
module iopmp_seq_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = en && (r_cnt == LAST);
endmodule

// File: rtl/iopmp_cfg_sequencer.sv
// Boot-time programming engine for the IOPMP control port. On start it walks
// the command slots and issues one TL-UL transaction per slot, one at a time,
// checking Get responses (and optional write readbacks) under a mask.
// Optional feature macro: IOPMP_CFG_READBACK_EN (write-then-readback check).
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   start_i           - begin a sequence (sampled in IDLE only)
//   num_cmds_i        - number of valid slots, 0 finishes immediately
//   cmd_*_i[]         - per-slot opcode, address, data, compare mask
//   tl_o / tl_i       - TL-UL host request / device response
//   busy_o, done_o    - sequence active, one-cycle completion pulse
//   error_o           - sticky error, cleared by the next accepted start
//   err_idx_o         - slot that failed
//   err_code_o        - 0 none, 1 d_error, 2 data mismatch, 3 timeout
//
// state    | meaning
// IDLE     | waiting for start_i
// REQ      | A-channel request for slot idx held until a_ready
// RSP      | waiting for the D-channel response of slot idx
// CHK_REQ  | readback Get to the address just written
// CHK_RSP  | waiting for the readback response
// DONE     | one-cycle done_o, then IDLE
module iopmp_cfg_sequencer
    import top_pkg::*;
    import tlul_pkg::*;
    import iopmp_pkg::*;
#(
    parameter int                NUM_CMDS       = 16,
    parameter logic [TL_AIW-1:0] SOURCE_ID      = 8'hE7,
    parameter int                TIMEOUT_CYCLES = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start_i,
    input  logic [$clog2(NUM_CMDS+1)-1:0]     num_cmds_i,
    input  logic                              cmd_op_i    [NUM_CMDS],
    input  logic [TL_AW-1:0]                  cmd_addr_i  [NUM_CMDS],
    input  logic [TL_DW-1:0]                  cmd_data_i  [NUM_CMDS],
    input  logic [TL_DW-1:0]                  cmd_vmask_i [NUM_CMDS],
    output tl_h2d_t                           tl_o,
    input  tl_d2h_t                           tl_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              error_o,
    output logic [$clog2(NUM_CMDS)-1:0]       err_idx_o,
    output logic [1:0]                        err_code_o
);
    localparam int IW = $clog2(NUM_CMDS + 1);
    localparam int EW = $clog2(NUM_CMDS);

    iopmp_seq_state_e r_state, w_next;
    logic [IW-1:0]    r_idx, w_idx_next;
    logic [EW-1:0]    w_sel, w_sel_next;
    logic             r_error;
    iopmp_seq_err_e   r_err_code, w_err_code;
    logic [EW-1:0]    r_err_idx;
    tl_h2d_t          r_tl;
    iopmp_seq_cmd_t   w_cmd;
    logic             w_set_err, w_clr_err;
    logic             w_wait_state, w_state_chg, w_expired;
    logic             w_unused_tl;

    assign w_sel = r_idx[EW-1:0];
    assign w_cmd = '{op:    cmd_op_i[w_sel],
                     addr:  cmd_addr_i[w_sel],
                     data:  cmd_data_i[w_sel],
                     vmask: cmd_vmask_i[w_sel]};

    assign w_wait_state = (r_state == SEQ_REQ)     || (r_state == SEQ_RSP) ||
                          (r_state == SEQ_CHK_REQ) || (r_state == SEQ_CHK_RSP);
    assign w_state_chg  = (w_next != r_state);

    iopmp_seq_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (w_state_chg),
        .en      (w_wait_state),
        .expired (w_expired)
    );

    always_comb begin
        w_next     = r_state;
        w_idx_next = r_idx;
        w_set_err  = 1'b0;
        w_clr_err  = 1'b0;
        w_err_code = ERR_NONE;
        case (r_state)
            SEQ_IDLE: begin
                if (start_i) begin
                    w_clr_err  = 1'b1;
                    w_idx_next = '0;
                    w_next     = (num_cmds_i != '0) ? SEQ_REQ : SEQ_DONE;
                end
            end
            SEQ_REQ: begin
                // A completing handshake wins over a same-cycle expiry.
                if (r_tl.a_valid && tl_i.a_ready) begin
                    w_next = SEQ_RSP;
                end else if (w_expired) begin
                    w_set_err  = 1'b1;
                    w_err_code = ERR_TIMEOUT;
                end
            end
            SEQ_RSP: begin
                if (tl_i.d_valid) begin
                    if (tl_i.d_error) begin
                        w_set_err  = 1'b1;
                        w_err_code = ERR_DERR;
                    end else if (!w_cmd.op &&
                                 masked_mismatch(tl_i.d_data, w_cmd.data, w_cmd.vmask)) begin
                        w_set_err  = 1'b1;
                        w_err_code = ERR_MISMATCH;
`ifdef IOPMP_CFG_READBACK_EN
                    end else if (w_cmd.op && (w_cmd.vmask != '0)) begin
                        w_next = SEQ_CHK_REQ;
`endif
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                        w_next     = (w_idx_next == num_cmds_i) ? SEQ_DONE : SEQ_REQ;
                    end
                end else if (w_expired) begin
                    w_set_err  = 1'b1;
                    w_err_code = ERR_TIMEOUT;
                end
            end
`ifdef IOPMP_CFG_READBACK_EN
            SEQ_CHK_REQ: begin
                if (r_tl.a_valid && tl_i.a_ready) begin
                    w_next = SEQ_CHK_RSP;
                end else if (w_expired) begin
                    w_set_err  = 1'b1;
                    w_err_code = ERR_TIMEOUT;
                end
            end
            SEQ_CHK_RSP: begin
                if (tl_i.d_valid) begin
                    if (tl_i.d_error) begin
                        w_set_err  = 1'b1;
                        w_err_code = ERR_DERR;
                    end else if (masked_mismatch(tl_i.d_data, w_cmd.data, w_cmd.vmask)) begin
                        w_set_err  = 1'b1;
                        w_err_code = ERR_MISMATCH;
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                        w_next     = (w_idx_next == num_cmds_i) ? SEQ_DONE : SEQ_REQ;
                    end
                end else if (w_expired) begin
                    w_set_err  = 1'b1;
                    w_err_code = ERR_TIMEOUT;
                end
            end
`endif
            SEQ_DONE: w_next = SEQ_IDLE;
            default:  w_next = SEQ_IDLE;
        endcase
        if (w_set_err) begin
            w_next = SEQ_DONE;
        end
    end

    assign w_sel_next = w_idx_next[EW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= SEQ_IDLE;
            r_idx      <= '0;
            r_tl       <= '0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
            r_err_idx  <= '0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_next;

            if (w_clr_err) begin
                r_error    <= 1'b0;
                r_err_code <= ERR_NONE;
            end
            if (w_set_err) begin
                r_error    <= 1'b1;
                r_err_code <= w_err_code;
                r_err_idx  <= w_sel;
            end

            // tl_o is built from the next state so it is fully registered;
            // A fields are loaded only on entry and therefore hold until a_ready.
            r_tl.d_ready <= (w_next == SEQ_RSP) || (w_next == SEQ_CHK_RSP);
            if ((w_next == SEQ_REQ) && (r_state != SEQ_REQ)) begin
                r_tl.a_valid   <= 1'b1;
                r_tl.a_opcode  <= cmd_op_i[w_sel_next] ? PutFullData : Get;
                r_tl.a_param   <= 3'b000;
                r_tl.a_size    <= 2'b10;
                r_tl.a_source  <= SOURCE_ID;
                r_tl.a_address <= cmd_addr_i[w_sel_next];
                r_tl.a_mask    <= '1;
                r_tl.a_data    <= cmd_data_i[w_sel_next];
`ifdef IOPMP_CFG_READBACK_EN
            end else if ((w_next == SEQ_CHK_REQ) && (r_state != SEQ_CHK_REQ)) begin
                // Address still holds the write just acknowledged.
                r_tl.a_valid  <= 1'b1;
                r_tl.a_opcode <= Get;
`endif
            end else if ((w_next != SEQ_REQ) && (w_next != SEQ_CHK_REQ)) begin
                r_tl.a_valid <= 1'b0;
            end
        end
    end

    assign tl_o       = r_tl;
    assign busy_o     = (r_state != SEQ_IDLE);
    assign done_o     = (r_state == SEQ_DONE);
    assign error_o    = r_error;
    assign err_idx_o  = r_err_idx;
    assign err_code_o = r_err_code;

    assign w_unused_tl = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size,
                           tl_i.d_source, tl_i.d_sink, w_cmd.addr};
endmodule
